// File: rtl/data_memory_mmio_pkg.sv
// data_memory_mmio_pkg: shared FSM states, MMIO offsets and debounce length
package data_memory_mmio_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  localparam int SW_OFFSET = 0;
  localparam int LED_OFFSET = 1;
  localparam int DEBOUNCE_LEN = 4;
endpackage

// File: rtl/mmio_switch_sync.sv
// mmio_switch_sync: two-flop switch synchroniser with optional debounce
// Ports: clock, reset (sync, active-high), d (async switches), q (synchronised).
// Optional: DMEM_SW_DEBOUNCE_EN makes each bit wait for DEBOUNCE_LEN stable cycles.
module mmio_switch_sync #(
  parameter int W = 18
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1, s2;
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end
`ifdef DMEM_SW_DEBOUNCE_EN
  import data_memory_mmio_pkg::*;
  logic [2:0] cnt [W];
  // A bit moves only after its synchronised value has disagreed with q for
  // DEBOUNCE_LEN consecutive cycles; any return to q restarts the count.
  always_ff @(posedge clock) begin
    for (int i = 0; i < W; i++) begin
      if (reset) begin
        cnt[i] <= '0;
        q[i]   <= 1'b0;
      end else if (s2[i] == q[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == 3'(DEBOUNCE_LEN - 1)) begin
        cnt[i] <= '0;
        q[i]   <= s2[i];
      end else begin
        cnt[i] <= cnt[i] + 3'd1;
      end
    end
  end
`else
  assign q = s2;
`endif
endmodule

// File: rtl/data_memory_mmio.sv
// data_memory_mmio: word-addressed RAM plus switch/LED MMIO behind a wait-state FSM
// Ports: clock, reset (sync, active-high); req_valid/req_ready/req_write/req_addr/
// req_wdata request channel; resp_valid/resp_rdata/resp_err response pulse;
// switches (async in), leds (registered out).
// Map: 0..DEPTH-1 RAM, DEPTH switches (RO), DEPTH+1 LEDs (RW), rest illegal.
// Optional: DMEM_SW_DEBOUNCE_EN enables switch debouncing in mmio_switch_sync.
module data_memory_mmio
  import data_memory_mmio_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 64,
  parameter int SW_W        = 18,
  parameter int LED_W       = 27,
  parameter int WAIT_STATES = 1,
  localparam int AW         = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  input  logic [SW_W-1:0]   switches,
  output logic [LED_W-1:0]  leds
);
  state_t            st;
  logic [3:0]        cnt;
  logic [AW-1:0]     a_q;
  logic              w_q;
  logic [DATA_W-1:0] d_q;
  logic [SW_W-1:0]   sw_s;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              is_ram, is_sw, is_led, err;
  mmio_switch_sync #(.W(SW_W)) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (switches),
    .q    (sw_s)
  );
  assign req_ready = st == ST_IDLE;
  // Decode works on the captured address, so it stays valid through WAIT/RESP.
  always_comb begin
    is_ram = !a_q[AW-1];
    is_sw  = a_q == AW'(DEPTH + SW_OFFSET);
    is_led = a_q == AW'(DEPTH + LED_OFFSET);
    err    = !(is_ram || is_sw || is_led) || (is_sw && w_q);
  end
  assign resp_valid = st == ST_RESP;
  assign resp_err   = resp_valid && err;
  assign resp_rdata = (!resp_valid || w_q || err) ? '0 :
                      is_ram ? mem[a_q[AW-2:0]] :
                      is_sw  ? DATA_W'(sw_s) : DATA_W'(leds);
  always_ff @(posedge clock) begin
    if (reset) begin
      st   <= ST_IDLE;
      cnt  <= '0;
      leds <= '0;
    end else if (req_valid && req_ready) begin
      a_q <= req_addr;
      w_q <= req_write;
      d_q <= req_wdata;
      cnt <= '0;
      st  <= WAIT_STATES > 0 ? ST_WAIT : ST_RESP;
    end else if (st == ST_WAIT) begin
      cnt <= cnt + 4'd1;
      st  <= cnt == 4'(WAIT_STATES - 1) ? ST_RESP : ST_WAIT;
    end else if (st == ST_RESP) begin
      st <= ST_IDLE;
      if (w_q && is_led) leds <= d_q[LED_W-1:0];
    end
  end
  // RAM is never cleared; a reset on the commit edge cancels the write.
  always_ff @(posedge clock) begin
    if (!reset && st == ST_RESP && w_q && is_ram) mem[a_q[AW-2:0]] <= d_q;
  end
endmodule

// File: tb/tb_data_memory_mmio.sv
// tb_data_memory_mmio: randomized self-checking bench for data_memory_mmio
module tb_data_memory_mmio;
  localparam int DEPTH = 64;
  localparam int WS = 1;
  logic        clock = 0;
  logic        reset = 1;
  logic        req_valid = 0, req_write = 0;
  logic        req_ready;
  logic [6:0]  req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic [17:0] switches = '0;
  logic [26:0] leds;
  logic [63:0] mem_m [DEPTH];
  logic [26:0] leds_m = '0;
  logic [17:0] sw_m = '0;
  int n_chk = 0, n_pass = 0;
  data_memory_mmio dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .switches(switches), .leds(leds)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic do_req(input logic wr, input logic [6:0] a, input logic [63:0] d);
    logic [63:0] er;
    logic ee;
    int g, k;
    er = '0;
    ee = 0;
    if (a < DEPTH) begin
      if (wr) mem_m[a] = d; else er = mem_m[a];
    end else if (a == DEPTH) begin
      if (wr) ee = 1; else er = 64'(sw_m);
    end else if (a == DEPTH + 1) begin
      if (wr) leds_m = d[26:0]; else er = 64'(leds_m);
    end else ee = 1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1;
    g = 0;
    while (!req_ready && g < 50) begin
      @(posedge clock); #1;
      g++;
    end
    check("ready", 64'(req_ready), 64'd1);
    @(posedge clock); #1;
    req_valid = 0;
    k = 1;
    while (!resp_valid && k < 20) begin
      @(posedge clock); #1;
      k++;
    end
    check("latency", 64'(k), 64'(WS + 1));
    check("rdata", resp_rdata, er);
    check("err", 64'(resp_err), 64'(ee));
    @(posedge clock); #1;
    check("pulse", 64'(resp_valid), 64'd0);
    check("leds", 64'(leds), 64'(leds_m));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int acc, rs;
    repeat (3) @(posedge clock);
    #1;
    check("rst_leds", 64'(leds), 64'd0);
    reset = 0;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    do_req(1, 7'd20, 64'd35);
    do_req(0, 7'd20, 64'd0);
    sw_m = 18'h30; switches = sw_m;
    repeat (6) @(posedge clock);
    #1;
    do_req(0, 7'(DEPTH), 64'd0);
    sw_m = 18'h15; switches = sw_m;
    repeat (6) @(posedge clock);
    #1;
    do_req(0, 7'(DEPTH), 64'd0);
    do_req(1, 7'(DEPTH + 1), 64'h5A5A);
    do_req(0, 7'(DEPTH + 1), 64'd0);
    do_req(0, 7'(DEPTH + 5), 64'd0);
    do_req(1, 7'(DEPTH), 64'd123);
    do_req(0, 7'(DEPTH), 64'd0);
    for (int i = 0; i < DEPTH; i++) do_req(1, 7'(i), {$urandom, $urandom});
    for (int i = 0; i < 80; i++) begin
      int kind;
      logic [6:0] a;
      if (i % 10 == 0) begin
        sw_m = 18'($urandom);
        switches = sw_m;
        repeat (8) @(posedge clock);
        #1;
      end
      kind = $urandom_range(0, 3);
      a = kind < 2 ? 7'($urandom_range(0, DEPTH - 1)) :
          kind == 2 ? 7'(DEPTH + $urandom_range(0, 1)) :
          7'($urandom_range(DEPTH + 2, 127));
      do_req(1'($urandom), a, {$urandom, $urandom});
    end
    req_write = 0; req_addr = 7'd20; req_valid = 1;
    acc = 0; rs = 0;
    for (int i = 0; i < 3 * (WS + 2); i++) begin
      acc += int'(req_ready);
      rs  += int'(resp_valid);
      if (resp_valid) check("b2b_rdata", resp_rdata, mem_m[20]);
      @(posedge clock); #1;
    end
    req_valid = 0;
    check("b2b_accepts", 64'(acc), 64'd3);
    check("b2b_resps", 64'(rs), 64'd3);
    do_req(1, 7'(DEPTH + 1), 64'h1234);
    req_write = 1; req_addr = 7'd7; req_wdata = 64'hDEAD; req_valid = 1;
    @(posedge clock); #1;
    req_valid = 0;
    check("mid_no_resp", 64'(resp_valid), 64'd0);
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    leds_m = '0;
    check("abort_resp", 64'(resp_valid), 64'd0);
    check("abort_ready", 64'(req_ready), 64'd1);
    check("abort_leds", 64'(leds), 64'd0);
    @(posedge clock); #1;
    check("abort_resp2", 64'(resp_valid), 64'd0);
    do_req(0, 7'd7, 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/data_memory_mmio.md
DATA_MEMORY_MMIO -- requirements
Module: data_memory_mmio

Interface
REQ-001 Parameter DATA_W, default 64, data word width in bits.
REQ-002 Parameter DEPTH, default 64, number of RAM words; power of two, at least 4.
REQ-003 Parameter SW_W, default 18, switch input width.
REQ-004 Parameter LED_W, default 27, LED output width.
REQ-005 Parameter WAIT_STATES, default 1, extra cycles per access; range 0..15.
REQ-006 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-007 Port: reset  input  1  synchronous, active-high reset.
REQ-008 Ports: req_valid in 1, req_ready out 1, req_write in 1, req_addr in $clog2(DEPTH)+1, req_wdata in DATA_W; request channel using word addressing.
REQ-009 Ports: resp_valid out 1, resp_rdata out DATA_W, resp_err out 1; response channel.
REQ-010 Ports: switches in SW_W (asynchronous source); leds out LED_W (registered).

Function
REQ-011 Address map: 0..DEPTH-1 is RAM; DEPTH is switch register (read-only); DEPTH+1 is LED register (read/write); all other addresses are illegal.
REQ-012 FSM states: IDLE, WAIT, RESP. req_ready=1 only in IDLE.
REQ-013 A request is accepted when req_valid and req_ready are both 1; address, data and write flag are captured at acceptance.
REQ-014 IDLE goes to WAIT on acceptance when WAIT_STATES>0, otherwise straight to RESP; WAIT counts WAIT_STATES cycles, then goes to RESP; RESP goes to IDLE after one cycle.
REQ-015 resp_valid is a one-cycle pulse in RESP; latency from the acceptance edge to resp_valid=1 is WAIT_STATES+1 cycles; no response backpressure.
REQ-016 A RAM write updates its word at the RESP edge; resp_rdata=0 for writes.
REQ-017 A RAM read returns the word's contents as of RESP.
REQ-018 A switch read returns the synchronised switches, zero-extended to DATA_W.
REQ-019 An LED write latches req_wdata[LED_W-1:0] into leds; an LED read returns leds zero-extended.
REQ-020 An illegal address asserts resp_err=1 and returns resp_rdata=0; no state changes, including for writes to the switch register.
REQ-021 Requests presented while not in IDLE are ignored and not queued.
REQ-022 switches pass through a two-flop synchroniser before any use.

Reset
REQ-023 Reset forces state=IDLE, wait counter=0, resp_valid=0, resp_rdata=0, resp_err=0, leds=0, and the synchroniser flops to 0.
REQ-024 Reset mid-transaction abandons the transaction: no response is produced, and the RAM is not written unless the write edge has already passed.
REQ-025 RAM contents are not cleared by reset and remain preloadable from a hex file by the bench.

Configuration
REQ-026 Macro DMEM_SW_DEBOUNCE_EN defined: each synchronised switch bit updates only after it has been stable for 4 consecutive cycles; the debounce counters reset to 0.
REQ-027 Macro DMEM_SW_DEBOUNCE_EN undefined: the synchroniser output is used directly, giving 2 cycles of latency.

Structure
REQ-028 Shared package holds the FSM state enum, the address-offset constants SW_OFFSET=0 and LED_OFFSET=1 (relative to DEPTH), and the debounce length constant 4.
REQ-029 One sub-module, mmio_switch_sync, implements the synchroniser and the optional debounce.

Verification
REQ-030 WAIT_STATES=1; write 35 to address 20, then read address 20 -> read resp_rdata=35, resp_err=0; resp_valid exactly 2 cycles after each acceptance.
REQ-031 switches=0x30 held for 6 cycles; read address DEPTH -> resp_rdata=0x30. Then switches=0x15 -> a read 6 cycles later returns 0x15.
REQ-032 Write 0x5A5A to address DEPTH+1 -> leds=0x5A5A after the RESP edge; read address DEPTH+1 -> resp_rdata=0x5A5A.
REQ-033 Read address DEPTH+5 -> resp_err=1, resp_rdata=0. Write to address DEPTH -> resp_err=1, switch register unaffected.
REQ-034 req_valid held high continuously -> a new acceptance occurs only in IDLE; 3 requests complete in 3*(WAIT_STATES+2) cycles.
REQ-035 Assert reset during WAIT of a write to address 7 -> no resp_valid, mem[7] unchanged, leds=0, req_ready=1 on the cycle after reset deasserts.
